// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field layout, opcodes, ALU ops
// and the multdiv occupancy FSM encoding.
package proc_pkg;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 27;
   localparam int RD_HI     = 26;
   localparam int RD_LO     = 22;
   localparam int RS_HI     = 21;
   localparam int RS_LO     = 17;
   localparam int RT_HI     = 16;
   localparam int RT_LO     = 12;
   localparam int ALUOP_HI  = 6;
   localparam int ALUOP_LO  = 2;

   localparam logic [4:0] OP_RTYPE = 5'd0;
   localparam logic [4:0] OP_BNE   = 5'd2;
   localparam logic [4:0] OP_JR    = 5'd4;
   localparam logic [4:0] OP_ADDI  = 5'd5;
   localparam logic [4:0] OP_BLT   = 5'd6;
   localparam logic [4:0] OP_SW    = 5'd7;
   localparam logic [4:0] OP_LW    = 5'd8;
   localparam logic [4:0] OP_BEX   = 5'd22;

   localparam logic [4:0] ALU_MUL  = 5'd6;
   localparam logic [4:0] ALU_DIV  = 5'd7;

   // bex implicitly reads the status register
   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd30;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } md_state_e;

   function automatic logic [4:0] f_opcode(input logic [31:0] instr);
      return instr[OPCODE_HI:OPCODE_LO];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] instr);
      return instr[RD_HI:RD_LO];
   endfunction

   function automatic logic [4:0] f_rs(input logic [31:0] instr);
      return instr[RS_HI:RS_LO];
   endfunction

   function automatic logic [4:0] f_rt(input logic [31:0] instr);
      return instr[RT_HI:RT_LO];
   endfunction

   function automatic logic [4:0] f_alu_op(input logic [31:0] instr);
      return instr[ALUOP_HI:ALUOP_LO];
   endfunction

endpackage

// File: rtl/pipeline_stall_control_load_use_detector.sv
// Flags a lw sitting in D/X whose destination is read by the instruction in F/D.
module load_use_detector
   import proc_pkg::*;
(
   input  logic [31:0] fd_instr,
   input  logic [31:0] dx_instr,
   output logic        stall
);

   logic [4:0] fd_op;
   logic [4:0] fd_rd;
   logic [4:0] fd_rs;
   logic [4:0] fd_rt;
   logic [4:0] dx_rd;
   logic       reads_dx_rd;
   logic       unused_bits;

   assign fd_op       = f_opcode(fd_instr);
   assign fd_rd       = f_rd(fd_instr);
   assign fd_rs       = f_rs(fd_instr);
   assign fd_rt       = f_rt(fd_instr);
   assign dx_rd       = f_rd(dx_instr);
   assign unused_bits = ^{fd_instr[11:0], dx_instr[21:0]};

   // sw store data lives in rd but is bypassed at M, so only its base (rs) counts
   always_comb begin
      reads_dx_rd = 1'b0;
      case (fd_op)
         OP_RTYPE:              reads_dx_rd = (fd_rs == dx_rd) || (fd_rt == dx_rd);
         OP_ADDI, OP_LW, OP_SW: reads_dx_rd = (fd_rs == dx_rd);
         OP_BNE, OP_BLT:        reads_dx_rd = (fd_rd == dx_rd) || (fd_rs == dx_rd);
         OP_JR:                 reads_dx_rd = (fd_rd == dx_rd);
         OP_BEX:                reads_dx_rd = (dx_rd == REG_STATUS);
         default:               reads_dx_rd = 1'b0;
      endcase
   end

   assign stall = (f_opcode(dx_instr) == OP_LW) && (dx_rd != REG_ZERO) && reads_dx_rd;

endmodule

// File: rtl/pipeline_stall_control.sv
// Stall/flush controller: load-use interlock, multdiv X-stage occupancy and
// redirect flush for the 5-stage pipeline.
module pipeline_stall_control
   import proc_pkg::*;
#(
   parameter int MULTDIV_TIMEOUT = 64,
   parameter int CNT_W           = 7
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] FD_Latch_Instr,
   input  logic [31:0] DX_Latch_Instr,
   input  logic        X_redirect,
   input  logic        multdiv_resultRDY,
   output logic        PC_enable,
   output logic        FD_enable,
   output logic        DX_enable,
   output logic        FD_flush,
   output logic        DX_flush,
   output logic        XM_bubble,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        multdiv_result_select,
   output logic        multdiv_timeout
);

   md_state_e        state;
   logic [CNT_W-1:0] counter;
   logic             dx_is_mul;
   logic             dx_is_div;
   logic             start_req;
   logic             timeout_hit;
   logic             md_release;
   logic             load_use_stall;

   load_use_detector u_load_use_detector (
      .fd_instr (FD_Latch_Instr),
      .dx_instr (DX_Latch_Instr),
      .stall    (load_use_stall)
   );

   assign dx_is_mul   = (f_opcode(DX_Latch_Instr) == OP_RTYPE) && (f_alu_op(DX_Latch_Instr) == ALU_MUL);
   assign dx_is_div   = (f_opcode(DX_Latch_Instr) == OP_RTYPE) && (f_alu_op(DX_Latch_Instr) == ALU_DIV);
   assign start_req   = (state == IDLE) && (dx_is_mul || dx_is_div) && !X_redirect;
   assign timeout_hit = (counter == CNT_W'(MULTDIV_TIMEOUT - 1));
   assign md_release  = (state == BUSY) && (multdiv_resultRDY || timeout_hit);

   // Counter is cleared on release so the next operation always starts from zero
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_req)
                  state <= START;
            end
            START: begin
               counter <= CNT_W'(1);
               state   <= BUSY;
            end
            BUSY: begin
               if (md_release) begin
                  counter <= '0;
                  state   <= IDLE;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            default: begin
               counter <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Redirects are ignored while multdiv owns X; a mul in D/X cannot be a branch
   always_comb begin
      PC_enable             = 1'b1;
      FD_enable             = 1'b1;
      DX_enable             = 1'b1;
      FD_flush              = 1'b0;
      DX_flush              = 1'b0;
      XM_bubble             = 1'b0;
      ctrl_MULT             = 1'b0;
      ctrl_DIV              = 1'b0;
      multdiv_result_select = 1'b0;
      multdiv_timeout       = 1'b0;
      if (!reset) begin
         if (md_release) begin
            multdiv_result_select = 1'b1;
            multdiv_timeout       = !multdiv_resultRDY;
         end else if ((state != IDLE) || start_req) begin
            PC_enable = 1'b0;
            FD_enable = 1'b0;
            DX_enable = 1'b0;
            XM_bubble = 1'b1;
            ctrl_MULT = start_req && dx_is_mul;
            ctrl_DIV  = start_req && dx_is_div;
         end else if (X_redirect) begin
            FD_flush = 1'b1;
            DX_flush = 1'b1;
         end else if (load_use_stall) begin
            PC_enable = 1'b0;
            FD_enable = 1'b0;
            DX_flush  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Directed bench for pipeline_stall_control; outputs are packed into one
// vector and compared against hand-derived patterns at the falling edge.
module tb_pipeline_stall_control;

   // Bit order: PC,FD,DX enables | FD,DX flush | XM_bubble | MULT,DIV | select | timeout
   localparam logic [9:0] NORMAL     = 10'b111_00_0_00_0_0;
   localparam logic [9:0] LU_STALL   = 10'b001_01_0_00_0_0;
   localparam logic [9:0] REDIRECT   = 10'b111_11_0_00_0_0;
   localparam logic [9:0] MUL_START  = 10'b000_00_1_10_0_0;
   localparam logic [9:0] DIV_START  = 10'b000_00_1_01_0_0;
   localparam logic [9:0] HOLD       = 10'b000_00_1_00_0_0;
   localparam logic [9:0] RELEASE    = 10'b111_00_0_00_1_0;
   localparam logic [9:0] TO_RELEASE = 10'b111_00_0_00_1_1;

   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] LW5      = 32'h4144_0000;
   localparam logic [31:0] LW0      = 32'h4004_0000;
   localparam logic [31:0] LW30     = 32'h4780_0000;
   localparam logic [31:0] ADD_R5   = 32'h018A_3000;
   localparam logic [31:0] ADD_R0   = 32'h0180_3000;
   localparam logic [31:0] SW5      = 32'h3948_0000;
   localparam logic [31:0] JR5      = 32'h2140_0000;
   localparam logic [31:0] BEX      = 32'hB000_0000;
   localparam logic [31:0] MUL7     = 32'h01C2_2018;
   localparam logic [31:0] DIV7     = 32'h01C2_201C;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] FD_Latch_Instr;
   logic [31:0] DX_Latch_Instr;
   logic        X_redirect;
   logic        multdiv_resultRDY;
   logic        PC_enable, FD_enable, DX_enable, FD_flush, DX_flush, XM_bubble;
   logic        ctrl_MULT, ctrl_DIV, multdiv_result_select, multdiv_timeout;
   logic [9:0]  outs;
   int          testsRun = 0;
   int          testsFailed = 0;

   always #5 clock = ~clock;

   pipeline_stall_control #(.MULTDIV_TIMEOUT(64), .CNT_W(7)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .FD_Latch_Instr        (FD_Latch_Instr),
      .DX_Latch_Instr        (DX_Latch_Instr),
      .X_redirect            (X_redirect),
      .multdiv_resultRDY     (multdiv_resultRDY),
      .PC_enable             (PC_enable),
      .FD_enable             (FD_enable),
      .DX_enable             (DX_enable),
      .FD_flush              (FD_flush),
      .DX_flush              (DX_flush),
      .XM_bubble             (XM_bubble),
      .ctrl_MULT             (ctrl_MULT),
      .ctrl_DIV              (ctrl_DIV),
      .multdiv_result_select (multdiv_result_select),
      .multdiv_timeout       (multdiv_timeout)
   );

   assign outs = {PC_enable, FD_enable, DX_enable, FD_flush, DX_flush, XM_bubble,
                  ctrl_MULT, ctrl_DIV, multdiv_result_select, multdiv_timeout};

   // Drive one cycle of inputs just after the rising edge, then settle at the falling edge
   task automatic applyStimulus(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                                input logic redir, input logic rdy);
      @(posedge clock);
      #1;
      reset             = rst;
      FD_Latch_Instr    = fd;
      DX_Latch_Instr    = dx;
      X_redirect        = redir;
      multdiv_resultRDY = rdy;
      @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
      end
   endtask

   initial begin
      reset             = 1'b1;
      FD_Latch_Instr    = NOP;
      DX_Latch_Instr    = NOP;
      X_redirect        = 1'b0;
      multdiv_resultRDY = 1'b0;

      applyStimulus(1'b1, NOP, NOP, 1'b0, 1'b0);
      checkOutput("reset_idle", outs, NORMAL);
      applyStimulus(1'b1, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("reset_mul_in_dx", outs, NORMAL);

      // Load-use interlock
      applyStimulus(1'b0, ADD_R5, LW5, 1'b0, 1'b0);
      checkOutput("lu_add", outs, LU_STALL);
      applyStimulus(1'b0, ADD_R5, NOP, 1'b0, 1'b0);
      checkOutput("lu_after", outs, NORMAL);
      applyStimulus(1'b0, SW5, LW5, 1'b0, 1'b0);
      checkOutput("lu_sw_data", outs, NORMAL);
      applyStimulus(1'b0, ADD_R0, LW0, 1'b0, 1'b0);
      checkOutput("lu_rd_zero", outs, NORMAL);
      applyStimulus(1'b0, JR5, LW5, 1'b0, 1'b0);
      checkOutput("lu_jr", outs, LU_STALL);
      applyStimulus(1'b0, BEX, LW30, 1'b0, 1'b0);
      checkOutput("lu_bex", outs, LU_STALL);
      applyStimulus(1'b0, BEX, LW5, 1'b0, 1'b0);
      checkOutput("lu_bex_other", outs, NORMAL);

      // Redirect overrides the interlock
      applyStimulus(1'b0, ADD_R5, LW5, 1'b1, 1'b0);
      checkOutput("redirect_over_lu", outs, REDIRECT);

      // Multiply released by RDY 17 cycles after the start pulse
      applyStimulus(1'b0, ADD_R5, MUL7, 1'b0, 1'b0);
      checkOutput("mul_start", outs, MUL_START);
      for (int i = 1; i < 17; i++) begin
         applyStimulus(1'b0, ADD_R5, MUL7, (i == 8), 1'b0);
         checkOutput($sformatf("mul_hold_%0d", i), outs, HOLD);
      end
      applyStimulus(1'b0, ADD_R5, MUL7, 1'b0, 1'b1);
      checkOutput("mul_release", outs, RELEASE);

      // Back-to-back multiply starts from IDLE on the cycle after release
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul2_start", outs, MUL_START);
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul2_start_state", outs, HOLD);
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b1);
      checkOutput("mul2_release", outs, RELEASE);
      applyStimulus(1'b0, NOP, NOP, 1'b0, 1'b0);
      checkOutput("mul2_idle", outs, NORMAL);

      // Divide with no RDY: forced release on cycle 64
      applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b0);
      checkOutput("div_start", outs, DIV_START);
      for (int i = 1; i < 64; i++) begin
         applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b0);
         checkOutput($sformatf("div_hold_%0d", i), outs, HOLD);
      end
      applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b0);
      checkOutput("div_timeout", outs, TO_RELEASE);
      applyStimulus(1'b0, NOP, NOP, 1'b0, 1'b0);
      checkOutput("div_after_timeout", outs, NORMAL);

      // RDY on the timeout cycle wins: no timeout pulse
      applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b0);
      checkOutput("div2_start", outs, DIV_START);
      for (int i = 1; i < 64; i++)
         applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b0);
      checkOutput("div2_last_hold", outs, HOLD);
      applyStimulus(1'b0, NOP, DIV7, 1'b0, 1'b1);
      checkOutput("div2_rdy_and_timeout", outs, RELEASE);

      // Reset in the middle of BUSY abandons the operation
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul3_start", outs, MUL_START);
      for (int i = 1; i < 5; i++)
         applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul3_busy", outs, HOLD);
      applyStimulus(1'b1, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul3_reset", outs, NORMAL);
      applyStimulus(1'b0, NOP, NOP, 1'b0, 1'b0);
      checkOutput("post_reset_idle", outs, NORMAL);
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul4_start", outs, MUL_START);
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b0);
      checkOutput("mul4_start_state", outs, HOLD);
      applyStimulus(1'b0, NOP, MUL7, 1'b0, 1'b1);
      checkOutput("mul4_release", outs, RELEASE);
      applyStimulus(1'b0, ADD_R5, LW5, 1'b0, 1'b0);
      checkOutput("final_lu", outs, LU_STALL);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_control.md
Name: pipeline_stall_control

Overview:
- Stall/flush controller for the 5-stage pipeline. Sits beside the F/D and D/X latches.
- Produces latch and PC enables, bubble insertion, and the multdiv start pulses.
- Covers three cases: load-use interlock (D/X lw feeding F/D), multi-cycle mult/div occupancy of the X stage, and control-flow flush on taken branch/jump resolved in X.
- Runs alongside the bypass selection logic; together they cover every data hazard.

Parameters:
MULTDIV_TIMEOUT, 64, max cycles in BUSY before forced release
CNT_W, 7, width of busy-cycle counter (must hold MULTDIV_TIMEOUT)

Ports:
clock  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high
FD_Latch_Instr  in  32  instruction in F/D latch
DX_Latch_Instr  in  32  instruction in D/X latch
X_redirect  in  1  taken branch/j/jal/jr/bex resolved in X this cycle
multdiv_resultRDY  in  1  multdiv result valid this cycle
PC_enable  out  1  PC register write enable
FD_enable  out  1  F/D latch write enable
DX_enable  out  1  D/X latch write enable
FD_flush  out  1  F/D loads nop (0x00000000) at next edge
DX_flush  out  1  D/X loads nop at next edge
XM_bubble  out  1  X/M loads nop instead of X-stage result
ctrl_MULT  out  1  one-cycle multdiv start, multiply
ctrl_DIV  out  1  one-cycle multdiv start, divide
multdiv_result_select  out  1  X stage drives X/M from multdiv result
multdiv_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Decode fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], ALU_op[6:2].
- Opcodes used: R=0, addi=5, sw=7, lw=8, bne=2, blt=6, jr=4, bex=22. ALU_op mul=6, div=7.
- Reset (while reset=1):
  - state<=IDLE, counter<=0.
  - All outputs 0, except the enables, which are 1.
  - Flushes are 0; the latches have their own reset.
- FSM states: IDLE, START, BUSY.
- IDLE:
  - If DX is R-type with ALU_op mul/div and X_redirect=0: assert ctrl_MULT or ctrl_DIV for this cycle only, then go to START.
  - PC, FD and DX are held. XM_bubble=1.
- START:
  - Counter<=1, go to BUSY.
  - Hold and bubble as in IDLE.
- BUSY:
  - Hold PC/FD/DX, XM_bubble=1, counter++.
  - On multdiv_resultRDY=1: multdiv_result_select=1, all enables 1, XM_bubble=0, go to IDLE.
  - On counter==MULTDIV_TIMEOUT-1 with no RDY: same release, plus a multdiv_timeout pulse.
  - RDY and timeout on the same cycle: treated as RDY, no timeout pulse.
- Back-to-back mul: the second mul enters DX on the release edge. IDLE then starts it on the next cycle, one idle cycle between operations.
- Load-use stall (combinational, IDLE only):
  - Condition: DX opcode=lw, DX rd≠0, and FD reads DX rd.
  - Reads by FD opcode:
    - R: rs or rt.
    - addi/lw/sw: rs.
    - bne/blt: rd or rs.
    - jr: rd.
    - bex: rd==30.
  - sw data (rd) is excluded; it is bypassed at M.
  - Response: PC_enable=0, FD_enable=0, DX_flush=1 (one bubble). Exactly one cycle per lw.
- Redirect (X_redirect=1):
  - FD_flush=1, DX_flush=1, PC_enable=1.
  - Overrides load-use stall.
  - Cannot coincide with START/BUSY: a mul in DX is not a branch. If it does anyway, redirect is ignored while not IDLE.
- Priority: reset > multdiv (START/BUSY) > redirect > load-use > normal flow (all enables 1, all flushes 0).
- No output is registered except the start pulses and timeout pulse, which derive from state. Outputs are valid the same cycle as the inputs.
- Reset asserted mid-BUSY: next cycle is IDLE with counter=0. No pulse is emitted, and the multdiv result is discarded.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode and ALU_op localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BNE, OP_BLT, OP_JR, OP_BEX, ALU_MUL, ALU_DIV).
  - Field bit ranges.
  - The FSM state encoding (2-bit IDLE/START/BUSY).
- Sub-module: load_use_detector, purely combinational. Inputs are the FD and DX instructions; output is a stall bit.
- The FSM and counter stay in the top.

Test Plan:
1. lw $5,0($2) (0x41440000) in DX, add $6,$5,$3 (0x018A3000) in FD → PC_enable=0, FD_enable=0, DX_flush=1 for one cycle. Next cycle all enables 1.
2. lw $5 in DX, sw $5,0($4) (0x39480000) in FD → no stall (data-only dependence). Same lw with $0 as rd → no stall.
3. mul $7,$1,$2 (0x01C22018) in DX → ctrl_MULT=1 for one cycle. PC/FD/DX held and XM_bubble=1 until RDY asserted 17 cycles later. That cycle: multdiv_result_select=1 and enables 1. Following cycle: IDLE.
4. div in DX, RDY never asserted → release at cycle 64 with multdiv_timeout=1 for one cycle.
5. X_redirect=1 while the load-use condition holds → FD_flush=DX_flush=1, PC_enable=1, no stall.
6. reset=1 mid-BUSY (cycle 5) → next cycle IDLE, all enables 1, no ctrl_MULT/ctrl_DIV. A subsequent mul starts normally.
